// File: rtl/bpsk_pkg.sv
// Shared definitions for the BPSK modulator: FSM states and saturation limits.
package bpsk_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } bpsk_state_t;

   localparam int unsigned SAT_W_MAX = 64;

   // Largest positive two's-complement value for a w-bit sample
   function automatic logic [SAT_W_MAX-1:0] sat_pos_lim(input int unsigned w);
      return (SAT_W_MAX'(1) << (w - 1)) - SAT_W_MAX'(1);
   endfunction

   // Most negative two's-complement value for a w-bit sample
   function automatic logic [SAT_W_MAX-1:0] sat_neg_lim(input int unsigned w);
      return SAT_W_MAX'(1) << (w - 1);
   endfunction

endpackage

// File: rtl/bpsk_sat_neg.sv
// Combinational saturating negate: -x, with the most negative input clamped to the most positive.
module bpsk_sat_neg
   import bpsk_pkg::*;
#(
   parameter int unsigned DATA_W = 16
) (
   input  logic [DATA_W-1:0] din,
   output logic [DATA_W-1:0] dout
);

   localparam logic [DATA_W-1:0] POS_LIM = DATA_W'(sat_pos_lim(DATA_W));
   localparam logic [DATA_W-1:0] NEG_LIM = DATA_W'(sat_neg_lim(DATA_W));

   always_comb begin
      dout = (~din) + DATA_W'(1);
      if (din == NEG_LIM) begin
         dout = POS_LIM;
      end
   end

endmodule

// File: rtl/bpsk_mod.sv
// BPSK modulator: multiplies the carrier by +/-1 per payload bit, MSB first, SAMPLES_PER_BIT strobes per bit.
module bpsk_mod
   import bpsk_pkg::*;
#(
   parameter int unsigned SAMPLES_PER_BIT = 16,
   parameter int unsigned DATA_W          = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [7:0]        byte_data,
   input  logic              byte_valid,
   output logic              byte_ready,
   input  logic              sine_rdy,
   input  logic [DATA_W-1:0] sine_in,
   output logic [DATA_W-1:0] mod_out,
   output logic              mod_valid,
   output logic              busy
);

   localparam int unsigned       CNT_W    = $clog2(SAMPLES_PER_BIT);
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(SAMPLES_PER_BIT - 1);

   bpsk_state_t       state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [2:0]        bit_cnt_q, bit_cnt_d;
   logic [7:0]        shreg_q, shreg_d;
   logic [DATA_W-1:0] mod_out_q, mod_out_d;
   logic              mod_valid_q, mod_valid_d;
   logic [DATA_W-1:0] neg_sine;
   logic              last_sample;
   logic              xfer;

   bpsk_sat_neg #(.DATA_W(DATA_W)) u_sat_neg (
      .din  (sine_in),
      .dout (neg_sine)
   );

   // Ready in SEND only on the strobe that finishes the final bit, enabling gapless hand-off
   always_comb begin
      last_sample = (state_q == SEND) && sine_rdy && (cnt_q == CNT_LAST) && (bit_cnt_q == 3'd7);
      byte_ready  = !rst && ((state_q == IDLE) || last_sample);
      xfer        = byte_valid && byte_ready;
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      bit_cnt_d   = bit_cnt_q;
      shreg_d     = shreg_q;
      mod_out_d   = mod_out_q;
      mod_valid_d = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (xfer) begin
               shreg_d   = byte_data;
               cnt_d     = '0;
               bit_cnt_d = '0;
               state_d   = SEND;
            end
         end
         SEND: begin
            if (sine_rdy) begin
               mod_out_d   = shreg_q[7] ? sine_in : neg_sine;
               mod_valid_d = 1'b1;
               if (cnt_q == CNT_LAST) begin
                  cnt_d = '0;
                  if (bit_cnt_q == 3'd7) begin
                     bit_cnt_d = '0;
                     if (xfer) begin
                        shreg_d = byte_data;
                     end else begin
                        shreg_d = '0;
                        state_d = IDLE;
                     end
                  end else begin
                     shreg_d   = {shreg_q[6:0], 1'b0};
                     bit_cnt_d = bit_cnt_q + 3'd1;
                  end
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         bit_cnt_q   <= '0;
         shreg_q     <= '0;
         mod_out_q   <= '0;
         mod_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         bit_cnt_q   <= bit_cnt_d;
         shreg_q     <= shreg_d;
         mod_out_q   <= mod_out_d;
         mod_valid_q <= mod_valid_d;
      end
   end

   assign mod_out   = mod_out_q;
   assign mod_valid = mod_valid_q;
   assign busy      = (state_q == SEND);

endmodule
